// File: rtl/cordic_pkg.sv
// Shared definitions for the rotation/vectoring CORDIC pair: FSM encoding,
// Q2.14 constants, arctangent table and the 16-bit saturation helper.
package cordic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BUSY  = 2'b01,
        ST_SCALE = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    localparam logic signed [15:0] HALF_PI  = 16'sd25736;
    localparam logic signed [15:0] KINV_DEF = 16'sd9949;

    // atan(2^-i) in Q2.14
    localparam logic signed [15:0] ATAN_TBL [0:15] = '{
        16'sd12868, 16'sd7596, 16'sd4013, 16'sd2037,
        16'sd1022,  16'sd512,  16'sd256,  16'sd128,
        16'sd64,    16'sd32,   16'sd16,   16'sd8,
        16'sd4,     16'sd2,    16'sd1,    16'sd0
    };

    function automatic logic signed [15:0] sat16(input logic signed [33:0] v);
        if (v > 34'sd32767)
            return 16'sd32767;
        else if (v < -34'sd32768)
            return -16'sd32768;
        else
            return v[15:0];
    endfunction

endpackage

// File: rtl/cordic_rotation_if.sv
// Operand/result handshake bundle for the rotation CORDIC.
interface cordic_rotation_if;

    logic signed [15:0] x_in;
    logic signed [15:0] y_in;
    logic signed [15:0] theta_in;
    logic               operands_val;
    logic               in_ready;
    logic signed [15:0] x_out;
    logic signed [15:0] y_out;
    logic               out_valid;
    logic               ack;

    modport master (
        output x_in, y_in, theta_in, operands_val, ack,
        input  in_ready, x_out, y_out, out_valid
    );

    modport slave (
        input  x_in, y_in, theta_in, operands_val, ack,
        output in_ready, x_out, y_out, out_valid
    );

endinterface

// File: rtl/cordic_atan_lut.sv
// Combinational arctangent lookup, indexed by micro-rotation number.
module cordic_atan_lut
    import cordic_pkg::*;
(
    input  logic        [3:0]  i_idx,
    output logic signed [15:0] o_atan
);

    assign o_atan = ATAN_TBL[i_idx];

endmodule

// File: rtl/cordic_rotation.sv
// Iterative rotation-mode CORDIC: rotates (x_in, y_in) by theta_in with
// quadrant pre-rotation, ITER micro-rotations and a final 1/K scale.
module cordic_rotation
    import cordic_pkg::*;
#(
    parameter int                 ITER = 16,
    parameter logic signed [15:0] KINV = KINV_DEF
)
(
    input  logic               Clk,
    input  logic               Rst_n,
    cordic_rotation_if.slave   bus
);

    localparam logic [3:0] LAST_I = 4'(ITER - 1);

    state_e              r_state;
    state_e              w_next;
    logic signed [17:0]  r_x;
    logic signed [17:0]  r_y;
    logic signed [15:0]  r_z;
    logic        [3:0]   r_i;
    logic signed [15:0]  r_xo;
    logic signed [15:0]  r_yo;

    logic                w_cap;
    logic                w_step;
    logic                w_scale;
    logic                w_in_ready;
    logic                w_out_valid;
    logic signed [15:0]  w_atan;
    logic signed [17:0]  w_xs;
    logic signed [17:0]  w_ys;
    logic signed [17:0]  w_xin18;
    logic signed [17:0]  w_yin18;
    logic signed [17:0]  w_x0;
    logic signed [17:0]  w_y0;
    logic signed [15:0]  w_z0;
    logic signed [33:0]  w_px;
    logic signed [33:0]  w_py;

    cordic_atan_lut u_atan (
        .i_idx  (r_i),
        .o_atan (w_atan)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (bus.operands_val) w_next = ST_BUSY;
            ST_BUSY:  if (r_i == LAST_I)    w_next = ST_SCALE;
            ST_SCALE:                       w_next = ST_DONE;
            ST_DONE:  if (bus.ack)          w_next = ST_IDLE;
            default:                        w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_cap       = 1'b0;
        w_step      = 1'b0;
        w_scale     = 1'b0;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                w_cap      = bus.operands_val;
            end
            ST_BUSY:  w_step      = 1'b1;
            ST_SCALE: w_scale     = 1'b1;
            ST_DONE:  w_out_valid = 1'b1;
            default:  w_in_ready  = 1'b0;
        endcase
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.x_out     = r_xo;
    assign bus.y_out     = r_yo;

    // ---------------- datapath ----------------
    assign w_xin18 = {{2{bus.x_in[15]}}, bus.x_in};
    assign w_yin18 = {{2{bus.y_in[15]}}, bus.y_in};

    // Fold angles beyond +-pi/2 by an exact quarter turn so the residual
    // stays inside the table's convergence range.
    always_comb begin
        w_x0 = w_xin18;
        w_y0 = w_yin18;
        w_z0 = bus.theta_in;
        if (bus.theta_in > HALF_PI) begin
            w_x0 = -w_yin18;
            w_y0 = w_xin18;
            w_z0 = bus.theta_in - HALF_PI;
        end else if (bus.theta_in < -HALF_PI) begin
            w_x0 = w_yin18;
            w_y0 = -w_xin18;
            w_z0 = bus.theta_in + HALF_PI;
        end
    end

    assign w_xs = r_x >>> r_i;
    assign w_ys = r_y >>> r_i;
    assign w_px = 34'(r_x) * 34'(KINV);
    assign w_py = 34'(r_y) * 34'(KINV);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_x  <= '0;
            r_y  <= '0;
            r_z  <= '0;
            r_i  <= '0;
            r_xo <= '0;
            r_yo <= '0;
        end else begin
            if (w_cap) begin
                r_x <= w_x0;
                r_y <= w_y0;
                r_z <= w_z0;
                r_i <= '0;
            end else if (w_step) begin
                if (!r_z[15]) begin
                    r_x <= r_x - w_ys;
                    r_y <= r_y + w_xs;
                    r_z <= r_z - w_atan;
                end else begin
                    r_x <= r_x + w_ys;
                    r_y <= r_y - w_xs;
                    r_z <= r_z + w_atan;
                end
                r_i <= r_i + 4'd1;
            end
            if (w_scale) begin
                r_xo <= sat16(w_px >>> 14);
                r_yo <= sat16(w_py >>> 14);
            end
        end
    end

endmodule

// File: tb/tb_cordic_rotation.sv
// Randomized + directed bench for cordic_rotation against a real-valued
// rotation model.
module tb_cordic_rotation;

    logic Clk = 1'b0;
    logic Rst_n = 1'b0;

    cordic_rotation_if bus();

    cordic_rotation #(.ITER(16)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input int got, input int exp, input int tol);
        n_chk++;
        if (got > exp + tol || got < exp - tol) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    function automatic int ref_rot(input int x, input int y, input int th, input bit want_y);
        real t;
        real r;
        int  v;
        t = th / 16384.0;
        if (want_y) r = x * $sin(t) + y * $cos(t);
        else        r = x * $cos(t) - y * $sin(t);
        v = $rtoi(r >= 0.0 ? r + 0.5 : r - 0.5);
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
        return v;
    endfunction

    task automatic start_op(input int x, input int y, input int th);
        int w;
        w = 0;
        while (!bus.in_ready && w < 100) begin
            @(negedge Clk);
            w++;
        end
        if (w >= 100) chk("ready_timeout", 0, 1, 0);
        @(negedge Clk);
        bus.x_in         = 16'(x);
        bus.y_in         = 16'(y);
        bus.theta_in     = 16'(th);
        bus.operands_val = 1'b1;
        @(posedge Clk);
        #1 bus.operands_val = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(posedge Clk);
            #1 lat++;
        end while (!bus.out_valid && lat < 100);
    endtask

    task automatic do_ack();
        @(negedge Clk);
        bus.ack = 1'b1;
        @(posedge Clk);
        #1 bus.ack = 1'b0;
    endtask

    task automatic op_check(input string tag, input int x, input int y, input int th, input int tol);
        int lat;
        start_op(x, y, th);
        wait_done(lat);
        chk({tag, "_lat"}, lat, 17, 0);
        chk({tag, "_x"}, int'(bus.x_out), ref_rot(x, y, th, 1'b0), tol);
        chk({tag, "_y"}, int'(bus.y_out), ref_rot(x, y, th, 1'b1), tol);
        do_ack();
    endtask

    initial begin
        int lat;
        int sx;
        int sy;
        int rx;
        int ry;
        int rt;
        bus.x_in         = '0;
        bus.y_in         = '0;
        bus.theta_in     = '0;
        bus.operands_val = 1'b0;
        bus.ack          = 1'b0;

        #12;
        chk("rst_in_ready", int'(bus.in_ready), 1, 0);
        chk("rst_out_valid", int'(bus.out_valid), 0, 0);
        chk("rst_x_out", int'(bus.x_out), 0, 0);
        chk("rst_y_out", int'(bus.y_out), 0, 0);
        @(negedge Clk);
        Rst_n = 1'b1;

        op_check("zero_ang", 16384, 0, 0, 4);
        op_check("pi_4", 16384, 0, 12868, 4);
        op_check("quad_pos", 16384, 0, 30000, 6);
        op_check("quad_neg", 16384, 0, -25736, 4);
        op_check("sat", 32767, 32767, 12868, 4);
        chk("sat_y_exact", int'(bus.y_out), 32767, 0);

        // result must hold while ack is withheld
        start_op(-12000, 9000, 7000);
        wait_done(lat);
        sx = int'(bus.x_out);
        sy = int'(bus.y_out);
        chk("hold_x_ref", sx, ref_rot(-12000, 9000, 7000, 1'b0), 6);
        for (int k = 0; k < 10; k++) begin
            @(negedge Clk);
            chk("hold_valid", int'(bus.out_valid), 1, 0);
            chk("hold_x", int'(bus.x_out), sx, 0);
            chk("hold_y", int'(bus.y_out), sy, 0);
        end
        do_ack();

        // operands_val pulsed while busy must not disturb the operation
        start_op(10000, -5000, -9000);
        lat = 0;
        do begin
            @(negedge Clk);
            if (lat == 4) begin
                bus.x_in         = 16'sd20000;
                bus.y_in         = 16'sd20000;
                bus.theta_in     = 16'sd20000;
                bus.operands_val = 1'b1;
            end else begin
                bus.operands_val = 1'b0;
            end
            @(posedge Clk);
            #1 lat++;
        end while (!bus.out_valid && lat < 100);
        bus.operands_val = 1'b0;
        chk("busy_pulse_lat", lat, 17, 0);
        chk("busy_pulse_x", int'(bus.x_out), ref_rot(10000, -5000, -9000, 1'b0), 6);
        chk("busy_pulse_y", int'(bus.y_out), ref_rot(10000, -5000, -9000, 1'b1), 6);

        // ack together with operands_val: return to idle, no capture
        @(negedge Clk);
        bus.ack          = 1'b1;
        bus.operands_val = 1'b1;
        bus.theta_in     = 16'sd1000;
        @(posedge Clk);
        #1;
        bus.ack          = 1'b0;
        bus.operands_val = 1'b0;
        chk("ackval_ready", int'(bus.in_ready), 1, 0);
        chk("ackval_valid", int'(bus.out_valid), 0, 0);
        @(posedge Clk);
        #1 chk("ackval_nocap", int'(bus.in_ready), 1, 0);

        // asynchronous reset in the middle of the iterations
        start_op(16384, 0, 5000);
        repeat (7) @(posedge Clk);
        #2 Rst_n = 1'b0;
        #1;
        chk("mrst_x_out", int'(bus.x_out), 0, 0);
        chk("mrst_y_out", int'(bus.y_out), 0, 0);
        chk("mrst_valid", int'(bus.out_valid), 0, 0);
        chk("mrst_ready", int'(bus.in_ready), 1, 0);
        @(negedge Clk);
        Rst_n = 1'b1;
        op_check("post_rst", 16384, 0, 5000, 4);

        for (int n = 0; n < 24; n++) begin
            rx = int'($urandom_range(0, 65535)) - 32768;
            ry = int'($urandom_range(0, 65535)) - 32768;
            rt = int'($urandom_range(0, 65535)) - 32768;
            op_check("rand", rx, ry, rt, 16);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
